// File: rtl/alu_pipe.sv
// Pipelined ARM data-processing ALU with valid/ready handshakes and an optional
// iterative shift-add multiplier (MUL/MLA) that stalls the input while it runs.
module alu_pipe #(
  parameter int WIDTH  = 32,
  parameter bit MUL_EN = 1'b1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       op,
  input  logic             mul,
  input  logic             acc_en,
  input  logic             setflags,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [WIDTH-1:0] c,
  input  logic [3:0]       flags_in,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic [3:0]       flags_out,
  output logic             writeback
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic {IDLE, MUL} state_t;

  state_t           r_state, w_stateNext;
  logic [CW-1:0]    r_cnt;
  logic [WIDTH-1:0] r_mulA, r_mulB, r_acc;
  logic             r_mulSetFlags;
  logic [3:0]       r_mulFlags;
  logic             r_outValid, r_writeback;
  logic [WIDTH-1:0] r_result;
  logic [3:0]       r_flags;

  logic             w_accept, w_isMul, w_outFree, w_lastStep, w_mulDone;
  logic [WIDTH-1:0] w_accNext;
  logic [3:0]       w_mulFlags;
  logic [WIDTH-1:0] w_x, w_y, w_logic, w_aluRes;
  logic             w_cin, w_arith, w_aluC, w_aluV, w_isTest;
  logic [WIDTH:0]   w_sum;
  logic [3:0]       w_aluFlags;

  assign w_isMul    = MUL_EN && mul;
  assign w_outFree  = !r_outValid || out_ready;
  assign in_ready   = rst_n && (r_state == IDLE) && w_outFree;
  assign w_accept   = in_valid && in_ready;
  assign w_lastStep = (r_state == MUL) && (r_cnt == CW'(WIDTH - 1));
  assign w_mulDone  = w_lastStep && w_outFree;
  assign w_accNext  = r_acc + (r_mulB[0] ? r_mulA : '0);
  assign w_mulFlags = r_mulSetFlags ? {w_accNext[WIDTH-1], w_accNext == '0, r_mulFlags[1:0]}
                                    : r_mulFlags;

  always_comb begin
    w_stateNext = r_state;
    case (r_state)
      IDLE:    if (w_accept && w_isMul) w_stateNext = MUL;
      MUL:     if (w_mulDone) w_stateNext = IDLE;
      default: w_stateNext = IDLE;
    endcase
  end

  // Adder operands: subtracts invert one side and use carry-in as NOT-borrow
  always_comb begin
    w_x     = a;
    w_y     = b;
    w_cin   = 1'b0;
    w_arith = 1'b1;
    w_logic = '0;
    case (op)
      4'd0, 4'd8:  begin w_arith = 1'b0; w_logic = a & b; end
      4'd1, 4'd9:  begin w_arith = 1'b0; w_logic = a ^ b; end
      4'd2, 4'd10: begin w_y = ~b; w_cin = 1'b1; end
      4'd3:        begin w_x = b; w_y = ~a; w_cin = 1'b1; end
      4'd4, 4'd11: w_cin = 1'b0;
      4'd5:        w_cin = flags_in[1];
      4'd6:        begin w_y = ~b; w_cin = flags_in[1]; end
      4'd7:        begin w_x = b; w_y = ~a; w_cin = flags_in[1]; end
      4'd12:       begin w_arith = 1'b0; w_logic = a | b; end
      4'd13:       begin w_arith = 1'b0; w_logic = b; end
      4'd14:       begin w_arith = 1'b0; w_logic = a & ~b; end
      4'd15:       begin w_arith = 1'b0; w_logic = ~b; end
      default:     w_arith = 1'b1;
    endcase
  end

  assign w_sum      = {1'b0, w_x} + {1'b0, w_y} + {{WIDTH{1'b0}}, w_cin};
  assign w_aluRes   = w_arith ? w_sum[WIDTH-1:0] : w_logic;
  assign w_aluC     = w_arith ? w_sum[WIDTH] : flags_in[1];
  assign w_aluV     = w_arith ? ((w_x[WIDTH-1] == w_y[WIDTH-1]) && (w_sum[WIDTH-1] != w_x[WIDTH-1]))
                              : flags_in[0];
  assign w_isTest   = (op[3:2] == 2'b10);
  assign w_aluFlags = (setflags || w_isTest) ? {w_aluRes[WIDTH-1], w_aluRes == '0, w_aluC, w_aluV}
                                             : flags_in;

  // The last step is held back (operands frozen) until the output register frees
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state       <= IDLE;
      r_cnt         <= '0;
      r_mulA        <= '0;
      r_mulB        <= '0;
      r_acc         <= '0;
      r_mulSetFlags <= 1'b0;
      r_mulFlags    <= '0;
    end else begin
      r_state <= w_stateNext;
      if (r_state == IDLE) begin
        if (w_accept && w_isMul) begin
          r_mulA        <= a;
          r_mulB        <= b;
          r_acc         <= acc_en ? c : '0;
          r_cnt         <= '0;
          r_mulSetFlags <= setflags;
          r_mulFlags    <= flags_in;
        end
      end else if (!w_lastStep) begin
        r_acc  <= w_accNext;
        r_mulA <= r_mulA << 1;
        r_mulB <= r_mulB >> 1;
        r_cnt  <= r_cnt + CW'(1);
      end else if (w_outFree) begin
        r_cnt <= '0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_outValid  <= 1'b0;
      r_result    <= '0;
      r_flags     <= '0;
      r_writeback <= 1'b0;
    end else if (w_accept && !w_isMul) begin
      r_outValid  <= 1'b1;
      r_result    <= w_aluRes;
      r_flags     <= w_aluFlags;
      r_writeback <= !w_isTest;
    end else if (w_mulDone) begin
      r_outValid  <= 1'b1;
      r_result    <= w_accNext;
      r_flags     <= w_mulFlags;
      r_writeback <= 1'b1;
    end else if (out_ready) begin
      r_outValid <= 1'b0;
    end
  end

  assign out_valid = r_outValid;
  assign result    = r_result;
  assign flags_out = r_flags;
  assign writeback = r_writeback;

endmodule

// File: tb/tb_alu_pipe.sv
// Self-checking bench for alu_pipe: directed corner cases plus randomized traffic
// scored against a plain-arithmetic reference model through a result queue.
module tb_alu_pipe;
  localparam int WIDTH = 32;
  localparam logic [3:0] OP_AND = 4'd0,  OP_EOR = 4'd1,  OP_SUB = 4'd2,  OP_RSB = 4'd3;
  localparam logic [3:0] OP_ADD = 4'd4,  OP_ADC = 4'd5,  OP_SBC = 4'd6,  OP_RSC = 4'd7;
  localparam logic [3:0] OP_TST = 4'd8,  OP_TEQ = 4'd9,  OP_CMP = 4'd10, OP_CMN = 4'd11;
  localparam logic [3:0] OP_ORR = 4'd12, OP_MOV = 4'd13, OP_BIC = 4'd14, OP_MVN = 4'd15;

  logic             clk, rst_n, in_valid, in_ready, mul, acc_en, setflags;
  logic             out_valid, out_ready, writeback;
  logic [3:0]       op, flags_in, flags_out;
  logic [WIDTH-1:0] a, b, c, result;

  typedef struct packed {
    logic             wb;
    logic [3:0]       flags;
    logic [WIDTH-1:0] res;
  } expect_t;

  expect_t          sbQueue[$];
  expect_t          popped, held;
  int               testCount, failCount, acceptCount, outCount;
  int               guard, streak;
  logic             readyRandom, readyForce, heldValid, stable;
  logic [WIDTH-1:0] firstRes;

  alu_pipe #(.WIDTH(WIDTH), .MUL_EN(1'b1)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .op(op), .mul(mul), .acc_en(acc_en), .setflags(setflags),
    .a(a), .b(b), .c(c), .flags_in(flags_in),
    .out_valid(out_valid), .out_ready(out_ready),
    .result(result), .flags_out(flags_out), .writeback(writeback)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    testCount++;
    if (observed !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: observed %0h, expected %0h", tag, observed, expected);
    end
  endtask

  // Reference: multiply via 64-bit product, V via signed range overflow
  function automatic expect_t refModel(input logic [3:0] fop, input logic fmul, input logic facc,
                                       input logic fs, input logic [WIDTH-1:0] fa,
                                       input logic [WIDTH-1:0] fb, input logic [WIDTH-1:0] fc,
                                       input logic [3:0] ffl);
    expect_t           e;
    longint unsigned   full;
    longint            ssum, maxS, minS;
    logic [WIDTH-1:0]  x, y, r;
    logic              cin, arith, cOut, vOut, isTest;
    if (fmul) begin
      full = longint'(fa) * longint'(fb);
      if (facc) full = full + longint'(fc);
      r = full[WIDTH-1:0];
      e.res = r;
      e.wb = 1'b1;
      e.flags = fs ? {r[WIDTH-1], r == '0, ffl[1:0]} : ffl;
      return e;
    end
    arith = 1'b1; cin = 1'b0; x = fa; y = fb; r = '0;
    case (fop)
      OP_SUB, OP_CMP: begin y = ~fb; cin = 1'b1; end
      OP_RSB:         begin x = fb; y = ~fa; cin = 1'b1; end
      OP_ADD, OP_CMN: cin = 1'b0;
      OP_ADC:         cin = ffl[1];
      OP_SBC:         begin y = ~fb; cin = ffl[1]; end
      OP_RSC:         begin x = fb; y = ~fa; cin = ffl[1]; end
      default:        arith = 1'b0;
    endcase
    if (arith) begin
      full = longint'(x) + longint'(y) + longint'(cin);
      r    = full[WIDTH-1:0];
      cOut = full[WIDTH];
      ssum = longint'($signed(x)) + longint'($signed(y)) + longint'(cin);
      maxS = (longint'(1) <<< (WIDTH - 1)) - 1;
      minS = -(longint'(1) <<< (WIDTH - 1));
      vOut = (ssum > maxS) || (ssum < minS);
    end else begin
      case (fop)
        OP_AND, OP_TST: r = fa & fb;
        OP_EOR, OP_TEQ: r = fa ^ fb;
        OP_ORR:         r = fa | fb;
        OP_MOV:         r = fb;
        OP_BIC:         r = fa & ~fb;
        default:        r = ~fb;
      endcase
      cOut = ffl[1];
      vOut = ffl[0];
    end
    isTest  = (fop == OP_TST) || (fop == OP_TEQ) || (fop == OP_CMP) || (fop == OP_CMN);
    e.res   = r;
    e.wb    = !isTest;
    e.flags = (fs || isTest) ? {r[WIDTH-1], r == '0, cOut, vOut} : ffl;
    return e;
  endfunction

  function automatic logic [WIDTH-1:0] pickOperand();
    case ($urandom_range(0, 7))
      0:       return '0;
      1:       return '1;
      2:       return {1'b0, {(WIDTH-1){1'b1}}};
      3:       return {1'b1, {(WIDTH-1){1'b0}}};
      default: return WIDTH'($urandom);
    endcase
  endfunction

  // Called at posedge+1; returns at posedge+1 right after the accepting edge
  task automatic applyStimulus(input logic [3:0] iop, input logic imul, input logic iacc,
                               input logic is, input logic [WIDTH-1:0] ia,
                               input logic [WIDTH-1:0] ib, input logic [WIDTH-1:0] ic,
                               input logic [3:0] ifl);
    int wait_n;
    wait_n = 0;
    op = iop; mul = imul; acc_en = iacc; setflags = is;
    a = ia; b = ib; c = ic; flags_in = ifl; in_valid = 1'b1;
    @(negedge clk);
    while (!in_ready && wait_n < 3000) begin
      @(negedge clk);
      wait_n++;
    end
    if (!in_ready) checkOutput("acceptTimeout", 64'(in_ready), 64'(1));
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    op = 4'($urandom); a = WIDTH'($urandom); b = WIDTH'($urandom);
    c = WIDTH'($urandom); flags_in = 4'($urandom); acc_en = 1'($urandom);
    setflags = 1'($urandom); mul = 1'($urandom);
  endtask

  task automatic expectNext(input string tag, input logic [WIDTH-1:0] res,
                            input logic [3:0] fl, input logic wb);
    @(negedge clk);
    checkOutput({tag, "Valid"}, 64'(out_valid), 64'(1));
    checkOutput({tag, "Res"}, 64'(result), 64'(res));
    checkOutput({tag, "Flags"}, 64'(flags_out), 64'(fl));
    checkOutput({tag, "Wb"}, 64'(writeback), 64'(wb));
    @(posedge clk);
    #1;
  endtask

  initial begin
    testCount = 0; failCount = 0; acceptCount = 0; outCount = 0;
    rst_n = 1'b0; in_valid = 1'b0; op = '0; mul = 1'b0; acc_en = 1'b0; setflags = 1'b0;
    a = '0; b = '0; c = '0; flags_in = '0; out_ready = 1'b1;
    readyRandom = 1'b0; readyForce = 1'b1; heldValid = 1'b0; held = '0;

    fork
      forever begin
        @(posedge clk);
        #2;
        out_ready = readyRandom ? ($urandom_range(0, 3) != 0) : readyForce;
      end
      forever begin
        @(negedge clk);
        if (!rst_n) begin
          sbQueue.delete();
          heldValid = 1'b0;
          acceptCount = 0;
          outCount = 0;
        end else begin
          if (heldValid)
            checkOutput("holdStable", 64'({out_valid, writeback, flags_out, result}),
                        64'({1'b1, held}));
          heldValid = out_valid && !out_ready;
          held = {writeback, flags_out, result};
          if (out_valid && out_ready) begin
            outCount++;
            if (sbQueue.size() == 0) begin
              checkOutput("spuriousOut", 64'(1), 64'(0));
            end else begin
              popped = sbQueue.pop_front();
              checkOutput("sbResult", 64'(result), 64'(popped.res));
              checkOutput("sbFlags", 64'(flags_out), 64'(popped.flags));
              checkOutput("sbWb", 64'(writeback), 64'(popped.wb));
            end
          end
          if (in_valid && in_ready) begin
            acceptCount++;
            sbQueue.push_back(refModel(op, mul, acc_en, setflags, a, b, c, flags_in));
          end
        end
      end
    join_none

    // Reset values
    repeat (3) @(negedge clk);
    checkOutput("rstValid", 64'(out_valid), 64'(0));
    checkOutput("rstResult", 64'(result), 64'(0));
    checkOutput("rstFlags", 64'(flags_out), 64'(0));
    checkOutput("rstWb", 64'(writeback), 64'(0));
    checkOutput("rstReady", 64'(in_ready), 64'(0));
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Directed ALU corner cases
    applyStimulus(OP_ADD, 1'b0, 1'b0, 1'b1, 32'h7FFF_FFFF, 32'h1, 32'h0, 4'b0000);
    expectNext("add", 32'h8000_0000, 4'b1001, 1'b1);
    applyStimulus(OP_SUB, 1'b0, 1'b0, 1'b1, 32'h0, 32'h1, 32'h0, 4'b0000);
    expectNext("sub", 32'hFFFF_FFFF, 4'b1000, 1'b1);
    applyStimulus(OP_CMP, 1'b0, 1'b0, 1'b0, 32'h5, 32'h5, 32'h0, 4'b0000);
    expectNext("cmp", 32'h0, 4'b0110, 1'b0);
    applyStimulus(OP_ADC, 1'b0, 1'b0, 1'b1, 32'hFFFF_FFFF, 32'h0, 32'h0, 4'b0010);
    expectNext("adc", 32'h0, 4'b0110, 1'b1);
    applyStimulus(OP_SBC, 1'b0, 1'b0, 1'b0, 32'd10, 32'd3, 32'h0, 4'b0000);
    expectNext("sbc", 32'd6, 4'b0000, 1'b1);

    // MLA latency: in_ready low and no output for WIDTH cycles
    applyStimulus(4'd0, 1'b1, 1'b1, 1'b1, 32'd7, 32'd6, 32'd100, 4'b0011);
    stable = 1'b1;
    repeat (WIDTH) begin
      @(negedge clk);
      if (in_ready !== 1'b0 || out_valid !== 1'b0) stable = 1'b0;
    end
    checkOutput("mlaStall", 64'(stable), 64'(1));
    expectNext("mla", 32'd142, 4'b0011, 1'b1);

    // Backpressure: first result held while further ADDs wait
    repeat (2) @(posedge clk);
    #1;
    readyForce = 1'b0;
    fork
      begin
        for (int i = 0; i < 5; i++)
          applyStimulus(OP_ADD, 1'b0, 1'b0, 1'b1, pickOperand(), pickOperand(), '0, 4'($urandom));
      end
      begin
        guard = 0;
        @(negedge clk);
        while (!out_valid && guard < 20) begin
          @(negedge clk);
          guard++;
        end
        checkOutput("bpFirstValid", 64'(out_valid), 64'(1));
        firstRes = result;
        stable = 1'b1;
        repeat (5) begin
          @(negedge clk);
          if (!(out_valid === 1'b1 && in_ready === 1'b0 && result === firstRes)) stable = 1'b0;
        end
        checkOutput("bpHold", 64'(stable), 64'(1));
        @(posedge clk);
        #1;
        readyForce = 1'b1;
        streak = 0;
        repeat (5) begin
          @(negedge clk);
          if (out_valid) streak++;
        end
        checkOutput("bpStream", 64'(streak), 64'(5));
      end
    join
    @(posedge clk);
    #1;

    // Asynchronous reset in the middle of a multiply discards it
    applyStimulus(4'd0, 1'b1, 1'b0, 1'b1, 32'd1234, 32'd5678, 32'd0, 4'b0000);
    repeat (10) @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    checkOutput("asyncRstValid", 64'(out_valid), 64'(0));
    checkOutput("asyncRstReady", 64'(in_ready), 64'(0));
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(negedge clk);
    checkOutput("postRstReady", 64'(in_ready), 64'(1));
    stable = 1'b1;
    repeat (40) begin
      @(negedge clk);
      if (out_valid !== 1'b0) stable = 1'b0;
    end
    checkOutput("mulDiscarded", 64'(stable), 64'(1));
    @(posedge clk);
    #1;
    applyStimulus(OP_AND, 1'b0, 1'b0, 1'b0, 32'hF0, 32'h3C, 32'h0, 4'b0000);
    expectNext("and", 32'h30, 4'b0000, 1'b1);

    // Randomized traffic with random backpressure
    readyRandom = 1'b1;
    for (int i = 0; i < 300; i++) begin
      applyStimulus(4'($urandom), ($urandom_range(0, 7) == 0), 1'($urandom), 1'($urandom),
                    pickOperand(), pickOperand(), pickOperand(), 4'($urandom));
      if ($urandom_range(0, 3) == 0) begin
        repeat ($urandom_range(1, 3)) @(posedge clk);
        #1;
      end
    end
    readyRandom = 1'b0;
    readyForce = 1'b1;
    guard = 0;
    while (sbQueue.size() != 0 && guard < 5000) begin
      @(negedge clk);
      guard++;
    end
    repeat (3) @(negedge clk);
    checkOutput("drainEmpty", 64'(sbQueue.size()), 64'(0));
    checkOutput("countMatch", 64'(outCount), 64'(acceptCount));

    $display("[TB] %0d tests run, %0d failed", testCount, failCount);
    $finish;
  end

endmodule
